mem_arbiter: RTL and testbench

Arbitrates the single shared main-memory port between the instruction-cache fill FSM, the data-cache fill FSM, and data-side write-through stores. Each requester gets exclusive ownership of the memory address/enable path for the whole transaction. Returned read data is steered back only to the current owner. The block sits between the two cache controllers and the multicycle memory model and contains the only memory-port ownership state in the design.

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Owns the single shared main-memory port. Grants it to the
//            I-cache fill FSM, the D-cache fill FSM, or a D-side
//            write-through store, and steers returned read-data valid
//            pulses back to whichever fill currently owns the port.
// Ports    :
//   clk, rst            clock, asynchronous active-high reset
//   i_req / i_addr      I-cache fill request (held for whole fill) + address
//   d_req / d_addr      D-cache fill request (held for whole fill) + address
//   d_wr_req/_addr/_data  store request (held until d_wr_ack), addr, data
//   mem_data_valid      read-data valid pulse from memory
//   mem_addr/_enable/_wr/_data_out  memory command port
//   i_grant / d_grant   fill ownership indicators
//   i_data_valid / d_data_valid  mem_data_valid steered to the owner
//   d_wr_ack            one-cycle store-complete pulse
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  input  logic              mem_data_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              i_grant,
  output logic              d_grant,
  output logic              i_data_valid,
  output logic              d_data_valid,
  output logic              d_wr_ack
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT_I = 2'd1;
  localparam logic [1:0] S_GRANT_D = 2'd2;
  localparam logic [1:0] S_WRITE   = 2'd3;

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [1:0] w_arb_state;
  // 1 = the I-side was the most recent fill owner; used to alternate fills.
  logic       r_last_fill;

  // Arbitration result, used whenever the port is (about to be) free.
  always_comb begin
    w_arb_state = S_IDLE;
    if (d_wr_req) begin
      w_arb_state = S_WRITE;
    end else if (d_req && i_req) begin
      w_arb_state = r_last_fill ? S_GRANT_D : S_GRANT_I;
    end else if (d_req) begin
      w_arb_state = S_GRANT_D;
    end else if (i_req) begin
      w_arb_state = S_GRANT_I;
    end
  end

  // Fills are never preempted; a dropping req hands over with no bubble.
  always_comb begin
    w_next_state = w_arb_state;
    case (r_state)
      S_GRANT_I: if (i_req) w_next_state = S_GRANT_I;
      S_GRANT_D: if (d_req) w_next_state = S_GRANT_D;
      default:   w_next_state = w_arb_state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last_fill <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_next_state == S_GRANT_I) begin
        r_last_fill <= 1'b1;
      end else if (w_next_state == S_GRANT_D) begin
        r_last_fill <= 1'b0;
      end
    end
  end

  // Output decode depends only on the state (plus the owner's data path),
  // so an asynchronous reset clears every output immediately.
  always_comb begin
    mem_addr     = '0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_data_out = '0;
    i_grant      = 1'b0;
    d_grant      = 1'b0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    d_wr_ack     = 1'b0;
    case (r_state)
      S_GRANT_I: begin
        mem_addr     = i_addr;
        mem_enable   = 1'b1;
        i_grant      = 1'b1;
        i_data_valid = mem_data_valid;
      end
      S_GRANT_D: begin
        mem_addr     = d_addr;
        mem_enable   = 1'b1;
        d_grant      = 1'b1;
        d_data_valid = mem_data_valid;
      end
      S_WRITE: begin
        mem_addr     = d_wr_addr;
        mem_data_out = d_wr_data;
        mem_enable   = 1'b1;
        mem_wr       = 1'b1;
        d_wr_ack     = 1'b1;
      end
      default: begin
        mem_addr = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. A port-ownership model
//            (who owns memory, who was served last) predicts every output.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_wr_req = 1'b0, mem_data_valid = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wr_addr = '0, d_wr_data = '0;
  logic [15:0] mem_addr, mem_data_out;
  logic        mem_enable, mem_wr, i_grant, d_grant, i_data_valid, d_data_valid, d_wr_ack;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_addr(d_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_data_valid(mem_data_valid),
    .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_data_out(mem_data_out),
    .i_grant(i_grant), .d_grant(d_grant),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .d_wr_ack(d_wr_ack)
  );

  always #5 clk = ~clk;

  wire [38:0] obs = {mem_addr, mem_enable, mem_wr, mem_data_out,
                     i_grant, d_grant, i_data_valid, d_data_valid, d_wr_ack};

  int n_checks = 0;
  int n_fail   = 0;

  // Ownership model: who holds the port, and whether the I-side was served last.
  localparam int O_NONE = 0, O_I = 1, O_D = 2, O_W = 3;
  int m_owner  = O_NONE;
  bit m_last_i = 1'b1;

  function automatic logic [38:0] model_out();
    case (m_owner)
      O_I: return {i_addr, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, mem_data_valid, 1'b0, 1'b0};
      O_D: return {d_addr, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, mem_data_valid, 1'b0};
      O_W: return {d_wr_addr, 1'b1, 1'b1, d_wr_data, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      default: return '0;
    endcase
  endfunction

  function automatic int model_pick();
    if (d_wr_req) return O_W;
    if (i_req && d_req) return m_last_i ? O_D : O_I;
    if (d_req) return O_D;
    if (i_req) return O_I;
    return O_NONE;
  endfunction

  function automatic void model_step();
    if (!((m_owner == O_I && i_req) || (m_owner == O_D && d_req))) begin
      m_owner = model_pick();
      if (m_owner == O_I) m_last_i = 1'b1;
      if (m_owner == O_D) m_last_i = 1'b0;
    end
  endfunction

  // Advance one clock; inputs only ever change 1 time unit after an edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_owner  = O_NONE;
      m_last_i = 1'b1;
    end else begin
      model_step();
    end
    #1;
  endtask

  task automatic clear_inputs();
    i_req = 0; d_req = 0; d_wr_req = 0; mem_data_valid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1; m_owner = O_NONE; m_last_i = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (obs !== 39'h0) begin n_fail++; $display("FAIL reset_outputs actual=%h required=0", obs); end
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++; if (obs !== 39'h0) begin n_fail++; $display("FAIL idle_outputs cyc=%0d actual=%h required=0", k, obs); end
    end
    i_req = 1'b1; i_addr = 16'h1230; #1;
    n_checks++; if (i_grant !== 1'b0) begin n_fail++; $display("FAIL grant_latency actual=%b required=0", i_grant); end
    tick();
    n_checks++; if ({i_grant, mem_addr, mem_enable} !== {1'b1, 16'h1230, 1'b1}) begin
      n_fail++; $display("FAIL first_i_grant actual=%b/%h/%b required=1/1230/1", i_grant, mem_addr, mem_enable); end
    mem_data_valid = 1'b1; #1;
    n_checks++; if ({i_data_valid, d_data_valid} !== 2'b10) begin
      n_fail++; $display("FAIL i_steer actual=%b required=10", {i_data_valid, d_data_valid}); end
    tick();
    mem_data_valid = 1'b0; i_req = 1'b0;
    tick();
    n_checks++; if (obs !== model_out()) begin n_fail++; $display("FAIL i_release actual=%h required=%h", obs, model_out()); end
  endtask

  task automatic test_alternation();
    do_reset();
    i_addr = 16'h4000; d_addr = 16'h8000;
    i_req = 1'b1; d_req = 1'b1;
    tick();
    n_checks++; if ({d_grant, i_grant, mem_addr} !== {1'b1, 1'b0, 16'h8000}) begin
      n_fail++; $display("FAIL alt_first_d actual=%b%b/%h required=10/8000", d_grant, i_grant, mem_addr); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (obs !== model_out()) begin n_fail++; $display("FAIL alt_hold_d actual=%h required=%h", obs, model_out()); end
    end
    d_req = 1'b0;
    tick();
    n_checks++; if ({i_grant, d_grant, mem_addr} !== {1'b1, 1'b0, 16'h4000}) begin
      n_fail++; $display("FAIL alt_i_no_bubble actual=%b%b/%h required=10/4000", i_grant, d_grant, mem_addr); end
    i_req = 1'b0;
    tick();
    n_checks++; if (obs !== 39'h0) begin n_fail++; $display("FAIL alt_idle actual=%h required=0", obs); end
    i_req = 1'b1; d_req = 1'b1;
    tick();
    n_checks++; if ({d_grant, i_grant} !== 2'b10) begin
      n_fail++; $display("FAIL alt_d_again actual=%b%b required=10", d_grant, i_grant); end
    d_req = 1'b0;
    tick();
    n_checks++; if (i_grant !== 1'b1) begin n_fail++; $display("FAIL alt_i_again actual=%b required=1", i_grant); end
    clear_inputs();
    tick();
  endtask

  task automatic test_write_during_fill();
    do_reset();
    i_addr = 16'h2222; i_req = 1'b1;
    tick();
    d_wr_req = 1'b1; d_wr_addr = 16'h00F0; d_wr_data = 16'hBEEF;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if ({mem_wr, d_wr_ack, i_grant} !== 3'b001) begin
        n_fail++; $display("FAIL no_preempt cyc=%0d actual=%b required=001", k, {mem_wr, d_wr_ack, i_grant}); end
    end
    i_req = 1'b0;
    tick();
    n_checks++; if ({mem_wr, mem_enable, d_wr_ack, mem_addr, mem_data_out, i_grant} !== {3'b111, 16'h00F0, 16'hBEEF, 1'b0}) begin
      n_fail++; $display("FAIL store_cycle actual=%b%b%b/%h/%h required=111/00f0/beef", mem_wr, mem_enable, d_wr_ack, mem_addr, mem_data_out); end
    d_wr_req = 1'b0;
    tick();
    n_checks++; if (obs !== 39'h0) begin n_fail++; $display("FAIL store_one_cycle actual=%h required=0", obs); end
  endtask

  task automatic test_all_three();
    do_reset();
    i_addr = 16'h1111; d_addr = 16'h2222; d_wr_addr = 16'h3333; d_wr_data = 16'h5A5A;
    i_req = 1'b1; d_req = 1'b1; d_wr_req = 1'b1;
    tick();
    n_checks++; if ({d_wr_ack, mem_wr, d_grant, i_grant} !== 4'b1100) begin
      n_fail++; $display("FAIL order_write actual=%b required=1100", {d_wr_ack, mem_wr, d_grant, i_grant}); end
    d_wr_req = 1'b0;
    tick();
    n_checks++; if ({d_grant, i_grant} !== 2'b10) begin n_fail++; $display("FAIL order_d actual=%b required=10", {d_grant, i_grant}); end
    for (int k = 0; k < 8; k++) begin
      mem_data_valid = 1'b1; #1;
      n_checks++; if ({i_data_valid, d_data_valid} !== 2'b01) begin
        n_fail++; $display("FAIL d_steer pulse=%0d actual=%b required=01", k, {i_data_valid, d_data_valid}); end
      tick();
      mem_data_valid = 1'b0;
      tick();
    end
    d_req = 1'b0;
    tick();
    n_checks++; if ({i_grant, d_grant} !== 2'b10) begin n_fail++; $display("FAIL order_i actual=%b required=10", {i_grant, d_grant}); end
    for (int k = 0; k < 8; k++) begin
      mem_data_valid = 1'b1; #1;
      n_checks++; if ({i_data_valid, d_data_valid} !== 2'b10) begin
        n_fail++; $display("FAIL i_steer8 pulse=%0d actual=%b required=10", k, {i_data_valid, d_data_valid}); end
      tick();
      mem_data_valid = 1'b0;
      tick();
    end
    i_req = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    d_addr = 16'hD00D; d_req = 1'b1;
    tick(); tick();
    n_checks++; if (d_grant !== 1'b1) begin n_fail++; $display("FAIL pre_reset_d actual=%b required=1", d_grant); end
    #2;
    rst = 1'b1; m_owner = O_NONE; m_last_i = 1'b1;
    #1;
    n_checks++; if (obs !== 39'h0) begin n_fail++; $display("FAIL async_reset actual=%h required=0", obs); end
    tick();
    rst = 1'b0;
    i_req = 1'b1;
    tick();
    n_checks++; if ({d_grant, i_grant} !== 2'b10) begin
      n_fail++; $display("FAIL post_reset_d_wins actual=%b required=10", {d_grant, i_grant}); end
    clear_inputs();
    tick();
  endtask

  task automatic test_stray_valid();
    do_reset();
    mem_data_valid = 1'b1; #1;
    n_checks++; if ({i_data_valid, d_data_valid} !== 2'b00) begin
      n_fail++; $display("FAIL stray_idle actual=%b required=00", {i_data_valid, d_data_valid}); end
    tick();
    mem_data_valid = 1'b0; #1;
    n_checks++; if (obs !== 39'h0) begin n_fail++; $display("FAIL stray_idle_state actual=%h required=0", obs); end
    d_wr_addr = 16'h0042; d_wr_data = 16'h1234; d_wr_req = 1'b1;
    tick();
    d_wr_req = 1'b0; mem_data_valid = 1'b1; #1;
    n_checks++; if ({i_data_valid, d_data_valid, d_wr_ack} !== 3'b001) begin
      n_fail++; $display("FAIL stray_write actual=%b required=001", {i_data_valid, d_data_valid, d_wr_ack}); end
    tick();
    mem_data_valid = 1'b0; i_req = 1'b1; i_addr = 16'h7777;
    tick();
    n_checks++; if ({i_grant, mem_addr} !== {1'b1, 16'h7777}) begin
      n_fail++; $display("FAIL stray_state_ok actual=%b/%h required=1/7777", i_grant, mem_addr); end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) i_req = ~i_req;
      if ($urandom_range(0, 5) == 0) d_req = ~d_req;
      d_wr_req       = ($urandom_range(0, 5) == 0);
      mem_data_valid = $urandom_range(0, 1);
      i_addr    = 16'($urandom);
      d_addr    = 16'($urandom);
      d_wr_addr = 16'($urandom);
      d_wr_data = 16'($urandom);
      #1;
      n_checks++; if (obs !== model_out()) begin
        n_fail++; $display("FAIL random cyc=%0d actual=%h required=%h", k, obs, model_out()); end
      n_checks++; if ($countones({i_grant, d_grant, d_wr_ack}) > 1) begin
        n_fail++; $display("FAIL exclusive cyc=%0d actual=%b required=onehot0", k, {i_grant, d_grant, d_wr_ack}); end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_alternation();
    test_write_during_fill();
    test_all_three();
    test_async_reset();
    test_stray_valid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
